// File: rtl/pipe_issue_scheduler_pkg.sv
// Shared types for the pipelined issue scheduler.
// Drain FSM encoding and counter width helper.
package pipe_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_issue_scheduler_tag_delay_line.sv
// Fixed-depth tag shift register that shadows the shared unit.
// Every stage clears on reset so no stale tag survives.
module tag_delay_line #(
  parameter int BITWIDTH    = 1,
  parameter int CYCLE_COUNT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITWIDTH-1:0] d,
  output logic [BITWIDTH-1:0] q
);

  logic [BITWIDTH-1:0] stg_q [CYCLE_COUNT];
  logic [BITWIDTH-1:0] stg_d [CYCLE_COUNT];

  always_comb begin
    stg_d[0] = d;
    for (int k = 1; k < CYCLE_COUNT; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CYCLE_COUNT; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CYCLE_COUNT; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign q = stg_q[CYCLE_COUNT-1];

endmodule

// File: rtl/pipe_issue_scheduler.sv
// Round-robin issue scheduler for a shared fixed-latency unit,
// with per-requester credits and a flush/drain handshake.
module pipe_issue_scheduler
  import pipe_issue_scheduler_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int LATENCY         = 8,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ID_W            = $clog2(NUM_REQ),
  localparam int CNT_W           = cnt_w(LATENCY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               unit_valid_in,
  output logic [ID_W-1:0]    unit_id_in,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               flush,
  output logic               drained,
  output logic [CNT_W-1:0]   inflight
);

  localparam int OUT_W = cnt_w(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] MAX_O =
    OUT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0] LAST_ID =
    ID_W'(NUM_REQ - 1);

  state_e state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [OUT_W-1:0] out_q [NUM_REQ];
  logic [OUT_W-1:0] out_d [NUM_REQ];
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               grant_en;
  logic               issue;
  logic               empty_next;
  logic [ID_W:0]      dl_in, dl_out;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && (out_q[i] < MAX_O);
    end
  end

  // First eligible requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant_en = rst_n && (state_q == RUN) && !flush;
  assign issue    = grant_en && found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = issue && (win == ID_W'(i));
    end
  end

  assign unit_valid_in = issue;
  assign unit_id_in    = issue ? win : '0;

  assign dl_in = {issue, unit_id_in};

  tag_delay_line #(
    .BITWIDTH   (ID_W + 1),
    .CYCLE_COUNT(LATENCY)
  ) u_tags (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dl_in),
    .q    (dl_out)
  );

  assign rsp_valid = dl_out[ID_W];
  assign rsp_id    = dl_out[ID_W-1:0];

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (win == LAST_ID) ? '0 : win + ID_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      out_d[i] = out_q[i];
      if (gnt[i] && !(rsp_valid && rsp_id == ID_W'(i))) begin
        out_d[i] = out_q[i] + OUT_W'(1);
      end else if (!gnt[i] && rsp_valid &&
                   rsp_id == ID_W'(i)) begin
        out_d[i] = out_q[i] - OUT_W'(1);
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !rsp_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && rsp_valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // No issue is possible while flushing, so only the return matters.
  assign empty_next = (inflight_q == '0) ||
                      (inflight_q == CNT_W'(1) && rsp_valid);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = empty_next ? DRAINED : DRAIN;
        end
      end
      DRAIN: begin
        if (empty_next) begin
          state_d = DRAINED;
        end
      end
      DRAINED: begin
        if (!flush) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign drained  = (state_q == DRAINED);
  assign inflight = inflight_q;

endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// Directed bench for pipe_issue_scheduler with default parameters.
// Inputs change 1 time unit after posedge; checks 2 units later.
module tb_pipe_issue_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       unit_valid_in;
  logic [1:0] unit_id_in;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       flush;
  logic       drained;
  logic [3:0] inflight;

  int total = 0;
  int bad   = 0;

  pipe_issue_scheduler #(
    .NUM_REQ        (4),
    .LATENCY        (8),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .gnt          (gnt),
    .unit_valid_in(unit_valid_in),
    .unit_id_in   (unit_id_in),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .flush        (flush),
    .drained      (drained),
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s c=%0d obs=%0h exp=%0h",
             tag, c, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    flush = 1'b0;
    #2;
    chk("rst_gnt", 0, gnt, 0);
    chk("rst_uvalid", 0, unit_valid_in, 0);
    chk("rst_uid", 0, unit_id_in, 0);
    chk("rst_rsp", 0, rsp_valid, 0);
    chk("rst_rspid", 0, rsp_id, 0);
    chk("rst_infl", 0, inflight, 0);
    chk("rst_drained", 0, drained, 0);

    // credit limit on a single requester
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      #2;
      chk("cr_gnt", c, gnt,
          ((c <= 3) || (c >= 9 && c <= 12)) ? 1 : 0);
      chk("cr_rsp", c, rsp_valid,
          (c >= 8 && c <= 11) ? 1 : 0);
      chk("cr_rspid", c, rsp_id, 0);
      if (c == 4 || c == 8) chk("cr_infl", c, inflight, 4);
      next_cyc();
    end

    // all requesters: strict rotation, inflight saturates
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      #2;
      chk("rr_gnt", c, gnt, 32'd1 << (c % 4));
      chk("rr_uid", c, unit_id_in, c % 4);
      chk("rr_uvalid", c, unit_valid_in, 1);
      chk("rr_infl", c, inflight, (c < 8) ? c : 8);
      chk("rr_rsp", c, rsp_valid, (c >= 8) ? 1 : 0);
      if (c >= 8) chk("rr_rspid", c, rsp_id, (c - 8) % 4);
      next_cyc();
    end

    // sparse requests
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("sp_gnt", c, gnt, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      next_cyc();
    end
    req = 4'b0100;
    #2;
    chk("sp_gnt2", 4, gnt, 4'b0100);
    chk("sp_uid2", 4, unit_id_in, 2);
    next_cyc();

    // flush with three in flight
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 15; c++) begin
      flush = (c >= 3 && c <= 12);
      #2;
      chk("dr_gnt", c, gnt, (c <= 2 || c == 14) ? 1 : 0);
      chk("dr_rsp", c, rsp_valid,
          (c >= 8 && c <= 10) ? 1 : 0);
      chk("dr_drained", c, drained,
          (c >= 11 && c <= 13) ? 1 : 0);
      if (c == 3) chk("dr_infl3", c, inflight, 3);
      if (c == 11) chk("dr_infl11", c, inflight, 0);
      next_cyc();
    end

    // flush in the same cycle as a request, empty pipe
    do_reset();
    req   = 4'b0001;
    flush = 1'b1;
    #2;
    chk("fs_gnt0", 0, gnt, 0);
    chk("fs_drn0", 0, drained, 0);
    next_cyc();
    flush = 1'b0;
    #2;
    chk("fs_drn1", 1, drained, 1);
    chk("fs_gnt1", 1, gnt, 0);
    next_cyc();
    #2;
    chk("fs_drn2", 2, drained, 0);
    chk("fs_gnt2", 2, gnt, 1);
    next_cyc();

    // asynchronous reset with five in flight
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("ar_gnt", c, gnt, 32'd1 << (c % 4));
      next_cyc();
    end
    #1;
    chk("ar_infl5", 5, inflight, 5);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 5, gnt, 0);
    chk("ar_uvalid", 5, unit_valid_in, 0);
    chk("ar_uid", 5, unit_id_in, 0);
    chk("ar_rsp", 5, rsp_valid, 0);
    chk("ar_rspid", 5, rsp_id, 0);
    chk("ar_infl", 5, inflight, 0);
    chk("ar_drained", 5, drained, 0);
    next_cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("ar_post_gnt", c, gnt, 32'd1 << (c % 4));
      chk("ar_post_rsp", c, rsp_valid, 0);
      next_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue_scheduler.md
# pipe_issue_scheduler

Round-robin issue scheduler that shares one fixed-latency, fully pipelined arithmetic unit among `NUM_REQ` requesters. Grants at most one issue per cycle and carries the requester ID through an internal reset-clearable delay line of `LATENCY` stages, so each result returns tagged with its owner. Applies per-requester credit limits and supports a flush/drain handshake before reconfiguration or mode switches in the HE datapath.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `LATENCY`, 8, unit pipeline depth in cycles (≥1)
- `MAX_OUTSTANDING`, 4, per-requester in-flight limit (≥1)
- `ID_W` (localparam), `$clog2(NUM_REQ)`, requester ID width
- `CNT_W` (localparam), `$clog2(LATENCY+1)`, in-flight counter width

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester issue request, level
- `gnt`  out  NUM_REQ  one-hot-or-zero grant, combinational
- `unit_valid_in`  out  1  issue strobe to shared unit, equals `|gnt`
- `unit_id_in`  out  ID_W  index of granted requester
- `rsp_valid`  out  1  result leaving unit this cycle
- `rsp_id`  out  ID_W  owner of returning result
- `flush`  in  1  level; block new grants and drain pipeline
- `drained`  out  1  pipeline empty, no grants while flush held
- `inflight`  out  CNT_W  total operations in the unit

## Operation
- Eligible[i] = `req[i]` and registered `outstanding[i]` < `MAX_OUTSTANDING`.
- Grant only in state RUN with `flush`=0 and `rst_n`=1; `gnt` forced 0 otherwise.
- Round-robin: search eligible from pointer `ptr` upward, wrapping. On grant to i, `ptr` ← (i+1) mod NUM_REQ. No grant → `ptr` unchanged. `ptr` resets to 0.
- `outstanding[i]`: +1 on grant to i, −1 on `rsp_valid` with `rsp_id`=i, unchanged if both same cycle. Width `$clog2(MAX_OUTSTANDING+1)`.
- `inflight`: +1 on issue, −1 on `rsp_valid`, unchanged if both. Never exceeds LATENCY.
- FSM states RUN, DRAIN, DRAINED:
  - RUN → DRAIN when `flush`=1 and pipeline not empty next; RUN → DRAINED when `flush`=1 and `inflight`=0.
  - DRAIN → DRAINED when `inflight`=0, or `inflight`=1 with `rsp_valid`=1.
  - DRAINED → RUN when `flush`=0; stays while `flush`=1.
  - DRAIN with `flush` deasserted: keeps draining to DRAINED, then RUN next cycle.
- `drained` = (state == DRAINED).
- Responses always delivered, including during DRAIN; no cancellation.

## Timing
- Issue in cycle t → `rsp_valid`/`rsp_id` registered output in cycle t+LATENCY.
- Credit return seen by eligibility in cycle after `rsp_valid`; no bypass.
- `flush` asserting in cycle t blocks the grant in cycle t itself.
- `drained` first high in cycle after last `rsp_valid`.
- Reset (async, immediate): `gnt`=0, `unit_valid_in`=0, `unit_id_in`=0, `rsp_valid`=0, `rsp_id`=0, `inflight`=0, `drained`=0, all `outstanding`=0, `ptr`=0, delay line cleared, state RUN. Reset mid-operation discards all in-flight tags; no stale response after release.

## Structure
- Shared package: FSM state enum (RUN, DRAIN, DRAINED), width helper for counters.
- Sub-module `tag_delay_line`: parameters BITWIDTH, CYCLE_COUNT; async active-low clear of every stage; carries {valid, id}, BITWIDTH=ID_W+1, CYCLE_COUNT=LATENCY.
- Arbiter, credit counters, FSM in top level.

## Test plan
- Credit limit: NUM_REQ=4, LATENCY=8, MAX=4, `req`=0001 held from cycle 0 → `gnt[0]` cycles 0–3, none 4–8, `rsp_valid` cycles 8–11 id 0, grants resume cycles 9–12.
- Fairness: `req`=1111 held, MAX=8 → grant order 0,1,2,3,0,1…; `inflight` saturates at 8 with issue+rsp every cycle.
- Sparse: `ptr`=0, `req`=1010 → grants 1,3,1,3; then `req`=0100 → grant 2 in next cycle.
- Drain: three issues at cycles 0–2, `flush`=1 at cycle 3 → no `gnt` from cycle 3, `rsp_valid` 8–10, `drained`=1 from cycle 11; `flush`=0 at 13 → grant possible at 14.
- Flush same cycle as request: `req`=0001, `flush`=1 cycle 0 with empty pipe → no grant, `drained`=1 cycle 1.
- Async reset at cycle 5 mid-cycle with 5 in flight → all outputs 0 immediately; after release no `rsp_valid` for 8 cycles, `ptr` restarts at 0.
